p4_router_ingress_frame_guard: RTL



---
 rtl/p4_router_ingress_guard_pkg.sv | 20 ++
 rtl/p4_router_ingress_guard_chan.sv | 196 +++++++++++++++++++
 rtl/p4_router_ingress_frame_guard.sv | 81 ++++++++
 3 files changed

// File: rtl/p4_router_ingress_guard_pkg.sv
// Shared types and constants for the ingress frame guard.
// This package holds the per-channel FSM encoding and the counter slot layout.
// Slot layout used in the flattened cnts vector: [0] good, [1] oversize,
// [2] runt/upstream-bad, [3] muted (dropped while disabled).
package p4_router_ingress_guard_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PASS,
    DROP,
    TRUNC
  } guard_state_t;

  localparam int CNT_GOOD       = 0;
  localparam int CNT_OVERSIZE   = 1;
  localparam int CNT_BAD        = 2;
  localparam int CNT_MUTED      = 3;
  localparam int NUM_GUARD_CNTS = 4;

endpackage

// File: rtl/p4_router_ingress_guard_chan.sv
// One ingress channel of the frame guard.
// The channel makes a frame-level admission decision on the first beat of
// each frame. It counts bytes and cuts frames that exceed the MTU. It tags
// frames that are runts or arrive marked bad from upstream. It keeps four
// saturating statistics counters.
// The output is a registered stage backed by a one-entry skid buffer. This
// gives full throughput with 1-cycle latency.
module p4_router_ingress_guard_chan
  import p4_router_ingress_guard_pkg::*;
#(
  parameter int DATA_BYTES      = 8,
  parameter int MTU_BYTES       = 1500,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                                    clk,
  input  logic                                    aresetn,
  input  logic                                    s_tvalid,
  output logic                                    s_tready,
  input  logic [DATA_BYTES*8-1:0]                 s_tdata,
  input  logic [DATA_BYTES-1:0]                   s_tkeep,
  input  logic                                    s_tlast,
  input  logic                                    s_tuser,
  output logic                                    m_tvalid,
  input  logic                                    m_tready,
  output logic [DATA_BYTES*8-1:0]                 m_tdata,
  output logic [DATA_BYTES-1:0]                   m_tkeep,
  output logic                                    m_tlast,
  output logic                                    m_tuser,
  input  logic                                    port_enable,
  input  logic                                    cnt_clear,
  output logic                                    port_connected,
  output logic [NUM_GUARD_CNTS*COUNTER_WIDTH-1:0] cnts
);

  localparam int DW  = DATA_BYTES * 8;
  // The byte count only grows while a frame is forwarded. One beat past the
  // MTU is the largest value it can ever hold.
  localparam int BCW = $clog2(MTU_BYTES + DATA_BYTES + 1);
  localparam logic [BCW-1:0] MTU_LIM = BCW'(MTU_BYTES);
  localparam logic [BCW-1:0] MIN_LIM = BCW'(MIN_FRAME_BYTES);

  guard_state_t state, state_nxt;
  logic [BCW-1:0] byte_cnt, byte_cnt_nxt;
  logic [BCW-1:0] beat_bytes, total;
  logic           rdy_en;
  logic           skid_full;
  logic [DW-1:0]  skid_data;
  logic [DATA_BYTES-1:0] skid_keep;
  logic           skid_last, skid_user;
  logic           accept, pass_beat;
  logic           fwd, fwd_last, fwd_user;
  logic [NUM_GUARD_CNTS-1:0] inc;
  logic [COUNTER_WIDTH-1:0]  cnt_q [NUM_GUARD_CNTS];

  // rdy_en keeps s_tready low while in reset and for the edge that releases it.
  assign s_tready   = rdy_en && !skid_full;
  assign accept     = s_tvalid && s_tready;
  assign beat_bytes = BCW'($countones(s_tkeep));
  // Forwarding beats: a frame start admitted by port_enable, or any PASS beat.
  assign pass_beat  = ((state == IDLE) && port_enable) || (state == PASS);

  // Frame FSM: admission, MTU cut, end-of-frame tagging and counter events.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    state_nxt    = state;
    byte_cnt_nxt = byte_cnt;
    fwd          = 1'b0;
    fwd_last     = 1'b0;
    fwd_user     = 1'b0;
    inc          = '0;
    total        = ((state == IDLE) ? '0 : byte_cnt) + beat_bytes;

    if (accept) begin
      if (pass_beat) begin
        fwd          = 1'b1;
        byte_cnt_nxt = total;
        if (total > MTU_LIM) begin
          // Cut here: this beat becomes the tagged last beat; the rest of the frame is discarded.
          fwd_last          = 1'b1;
          fwd_user          = 1'b1;
          inc[CNT_OVERSIZE] = 1'b1;
          state_nxt         = s_tlast ? IDLE : TRUNC;
        end else if (s_tlast) begin
          fwd_last     = 1'b1;
          fwd_user     = s_tuser || (total < MIN_LIM);
          inc[CNT_BAD] = fwd_user;
          inc[CNT_GOOD] = !fwd_user;
          state_nxt    = IDLE;
        end else begin
          state_nxt = PASS;
        end
      end else begin
        unique case (state)
          IDLE: begin
            // Disabled at frame start: the whole frame is muted.
            inc[CNT_MUTED] = s_tlast;
            state_nxt      = s_tlast ? IDLE : DROP;
          end
          DROP: begin
            if (s_tlast) begin
              inc[CNT_MUTED] = 1'b1;
              state_nxt      = IDLE;
            end
          end
          TRUNC: begin
            if (s_tlast) state_nxt = IDLE;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end
  end

  // State, byte count and the enable snapshot applied at frame boundaries.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state          <= IDLE;
      byte_cnt       <= '0;
      port_connected <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values
      // regardless of block ordering.
      state    <= state_nxt;
      byte_cnt <= byte_cnt_nxt;
      if (state == IDLE) port_connected <= port_enable;
    end
  end

  // Output register plus one-entry skid: a forwarded beat goes straight to the
  // output when it is free, otherwise it parks in the skid until the sink drains.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      rdy_en    <= 1'b0;
      skid_full <= 1'b0;
      skid_data <= '0;
      skid_keep <= '0;
      skid_last <= 1'b0;
      skid_user <= 1'b0;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeep   <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (!m_tvalid || m_tready) begin
        if (skid_full) begin
          m_tvalid  <= 1'b1;
          m_tdata   <= skid_data;
          m_tkeep   <= skid_keep;
          m_tlast   <= skid_last;
          m_tuser   <= skid_user;
          skid_full <= 1'b0;
        end else begin
          m_tvalid <= fwd;
          if (fwd) begin
            m_tdata <= s_tdata;
            m_tkeep <= s_tkeep;
            m_tlast <= fwd_last;
            m_tuser <= fwd_user;
          end
        end
      end else if (fwd) begin
        skid_full <= 1'b1;
        skid_data <= s_tdata;
        skid_keep <= s_tkeep;
        skid_last <= fwd_last;
        skid_user <= fwd_user;
      end
    end
  end

  // Saturating statistics; a clear strobe wins over a coincident increment.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      // NOTE: this small register array is software-visible, so it is reset;
      // a true storage RAM would not be.
      for (int i = 0; i < NUM_GUARD_CNTS; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_GUARD_CNTS; i++) begin
        if (cnt_clear) begin
          cnt_q[i] <= '0;
        end else if (inc[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + COUNTER_WIDTH'(1);
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_GUARD_CNTS; i++) begin : g_cnt_out
    assign cnts[i*COUNTER_WIDTH +: COUNTER_WIDTH] = cnt_q[i];
  end

endmodule

// File: rtl/p4_router_ingress_frame_guard.sv
// Ingress frame admission stage for the P4 router.
// The stage replicates one independent guard channel per port. It slices the
// flattened AXIS vectors per port, with no cross-port interaction.
module p4_router_ingress_frame_guard
  import p4_router_ingress_guard_pkg::*;
#(
  parameter int NUM_PORTS       = 4,
  parameter int DATA_BYTES      = 8,
  parameter int MTU_BYTES       = 1500,
  parameter int MIN_FRAME_BYTES = 64,
  parameter int COUNTER_WIDTH   = 32
) (
  input  logic                                              clk,
  input  logic                                              aresetn,
  input  logic [NUM_PORTS-1:0]                              s_tvalid,
  output logic [NUM_PORTS-1:0]                              s_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0]                 s_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]                   s_tkeep,
  input  logic [NUM_PORTS-1:0]                              s_tlast,
  input  logic [NUM_PORTS-1:0]                              s_tuser,
  output logic [NUM_PORTS-1:0]                              m_tvalid,
  input  logic [NUM_PORTS-1:0]                              m_tready,
  output logic [NUM_PORTS*DATA_BYTES*8-1:0]                 m_tdata,
  output logic [NUM_PORTS*DATA_BYTES-1:0]                   m_tkeep,
  output logic [NUM_PORTS-1:0]                              m_tlast,
  output logic [NUM_PORTS-1:0]                              m_tuser,
  input  logic [NUM_PORTS-1:0]                              port_enable,
  input  logic [NUM_PORTS-1:0]                              cnt_clear,
  output logic [NUM_PORTS-1:0]                              port_connected,
  output logic [NUM_PORTS*NUM_GUARD_CNTS*COUNTER_WIDTH-1:0] cnts
);

  localparam int DW = DATA_BYTES * 8;
  localparam int CW = NUM_GUARD_CNTS * COUNTER_WIDTH;

  // Reject parameter sets the channel logic cannot represent.
  if (NUM_PORTS < 1) begin : g_chk_ports
    $error("NUM_PORTS must be at least 1");
  end
  if (DATA_BYTES < 1) begin : g_chk_bytes
    $error("DATA_BYTES must be at least 1");
  end
  if (MTU_BYTES < DATA_BYTES) begin : g_chk_mtu
    $error("MTU_BYTES must be at least DATA_BYTES");
  end
  if ((MIN_FRAME_BYTES < 1) || (MIN_FRAME_BYTES > MTU_BYTES)) begin : g_chk_min
    $error("MIN_FRAME_BYTES must be in 1..MTU_BYTES");
  end
  if (COUNTER_WIDTH < 8) begin : g_chk_cw
    $error("COUNTER_WIDTH must be at least 8");
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
    p4_router_ingress_guard_chan #(
      .DATA_BYTES      (DATA_BYTES),
      .MTU_BYTES       (MTU_BYTES),
      .MIN_FRAME_BYTES (MIN_FRAME_BYTES),
      .COUNTER_WIDTH   (COUNTER_WIDTH)
    ) u_chan (
      .clk            (clk),
      .aresetn        (aresetn),
      .s_tvalid       (s_tvalid[p]),
      .s_tready       (s_tready[p]),
      .s_tdata        (s_tdata[p*DW +: DW]),
      .s_tkeep        (s_tkeep[p*DATA_BYTES +: DATA_BYTES]),
      .s_tlast        (s_tlast[p]),
      .s_tuser        (s_tuser[p]),
      .m_tvalid       (m_tvalid[p]),
      .m_tready       (m_tready[p]),
      .m_tdata        (m_tdata[p*DW +: DW]),
      .m_tkeep        (m_tkeep[p*DATA_BYTES +: DATA_BYTES]),
      .m_tlast        (m_tlast[p]),
      .m_tuser        (m_tuser[p]),
      .port_enable    (port_enable[p]),
      .cnt_clear      (cnt_clear[p]),
      .port_connected (port_connected[p]),
      .cnts           (cnts[p*CW +: CW])
    );
  end

endmodule
